// File: rtl/spi_dev_fwrite_if.sv
// spi_dev_fwrite_if: pw_* bus between the SPI protocol wrapper and a command
// decoder.
//
// Signals:
//   pw_wdata  byte written by the ESP32
//   pw_wcmd   pw_wdata is the command byte of a transaction
//   pw_wstb   pw_wdata valid strobe
//   pw_end    one-cycle pulse at end of SPI transaction (CS rise)
//   pw_req    decoder requests ownership of the read data path
//   pw_gnt    read path granted to the decoder
//   pw_rdata  byte returned to the ESP32
//   pw_rstb   pw_rdata consumed; present the next byte
//   pw_irq    decoder has work pending for the ESP32
//
// Modports: master = wrapper side, slave = decoder side.
interface spi_dev_fwrite_if;
    logic [7:0] pw_wdata;
    logic       pw_wcmd;
    logic       pw_wstb;
    logic       pw_end;
    logic       pw_req;
    logic       pw_gnt;
    logic [7:0] pw_rdata;
    logic       pw_rstb;
    logic       pw_irq;

    modport master (
        output pw_wdata, pw_wcmd, pw_wstb, pw_end, pw_gnt, pw_rstb,
        input  pw_req, pw_rdata, pw_irq
    );

    modport slave (
        input  pw_wdata, pw_wcmd, pw_wstb, pw_end, pw_gnt, pw_rstb,
        output pw_req, pw_rdata, pw_irq
    );
endinterface

// File: rtl/spi_dev_fwrite.sv
// spi_dev_fwrite: buffers a user payload destined for an ESP32 file and lets
// the ESP32 fetch header + payload over the pw_* bus.
//
// Optional feature macro: FWRITE_CHECKSUM_EN appends an 8-bit sum of the
// payload bytes to the stream.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   pw                          pw_* bus (slave side)
//   req_file_id/offset/len      request fields (len = payload length - 1)
//   req_valid / req_ready       request handshake
//   wr_data, wr_valid/wr_ready  payload byte handshake
//   done                        one-cycle pulse when the stream was fully read
//   state_dbg                   current FSM state (0 IDLE,1 FILL,2 PEND,3 XFER)
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; ready is decoded from registered state only, and valid must
// hold its data stable until that edge.
module spi_dev_fwrite #(
    parameter logic [7:0] CMD_BYTE = 8'hF9,
    parameter int         BUF_AW   = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_dev_fwrite_if.slave   pw,
    input  logic [31:0]       req_file_id,
    input  logic [31:0]       req_offset,
    input  logic [BUF_AW-1:0] req_len,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [7:0]        wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic              done,
    output logic [1:0]        state_dbg
);
    // Stream index needs to reach len + 12 with len up to 2**BUF_AW - 1.
    localparam int IW = BUF_AW + 2;
`ifdef FWRITE_CHECKSUM_EN
    localparam logic [IW-1:0] TAIL = IW'(12);
`else
    localparam logic [IW-1:0] TAIL = IW'(11);
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_PEND = 2'd2,
        S_XFER = 2'd3
    } state_t;

    state_t            state, state_nx;
    logic [31:0]       file_id, offset;
    logic [BUF_AW-1:0] len;
    logic [BUF_AW:0]   wcnt;
    logic [IW-1:0]     rd_idx, rd_idx_nx, idx_d, total, idx_step;
    logic [7:0]        mem [2**BUF_AW];
    logic [7:0]        mem_q;
    logic [BUF_AW-1:0] raddr;
    logic [7:0]        byte_sel;
    logic [15:0]       len16;
    logic              done_nx, req_fire, wr_fire, cmd_hit;
`ifdef FWRITE_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign total     = IW'(len) + TAIL;
    assign len16     = 16'(len);
    assign req_ready = (state == S_IDLE);
    assign wr_ready  = (state == S_FILL) && (wcnt <= {1'b0, len});
    assign req_fire  = req_valid & req_ready;
    assign wr_fire   = wr_valid & wr_ready;
    assign cmd_hit   = pw.pw_wstb & pw.pw_wcmd & (pw.pw_wdata == CMD_BYTE);
    assign pw.pw_irq = (state == S_PEND);
    assign pw.pw_req = (state == S_XFER);
    assign state_dbg = state;

    // A strobe at the last index is absorbed so the index saturates there.
    assign idx_step = (pw.pw_rstb && (rd_idx != total)) ? rd_idx + IW'(1) : rd_idx;

    always_comb begin
        state_nx  = state;
        rd_idx_nx = rd_idx;
        done_nx   = 1'b0;
        case (state)
            S_IDLE: begin
                rd_idx_nx = '0;
                if (req_fire) state_nx = S_FILL;
            end
            S_FILL: begin
                if (wr_fire && (wcnt == {1'b0, len})) state_nx = S_PEND;
            end
            S_PEND: begin
                if (cmd_hit) state_nx = S_XFER;
            end
            S_XFER: begin
                rd_idx_nx = idx_step;
                // The strobe of this cycle is already folded into idx_step.
                if (pw.pw_end) begin
                    rd_idx_nx = '0;
                    if (idx_step == total) begin
                        done_nx  = 1'b1;
                        state_nx = S_IDLE;
                    end else begin
                        state_nx = S_PEND;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Output byte for the index that mem_q currently corresponds to.
    always_comb begin
        byte_sel = 8'h00;
        if (idx_d < IW'(10)) begin
            case (idx_d[3:0])
                4'd0:    byte_sel = file_id[31:24];
                4'd1:    byte_sel = file_id[23:16];
                4'd2:    byte_sel = file_id[15:8];
                4'd3:    byte_sel = file_id[7:0];
                4'd4:    byte_sel = offset[31:24];
                4'd5:    byte_sel = offset[23:16];
                4'd6:    byte_sel = offset[15:8];
                4'd7:    byte_sel = offset[7:0];
                4'd8:    byte_sel = len16[15:8];
                4'd9:    byte_sel = len16[7:0];
                default: byte_sel = 8'h00;
            endcase
        end else if (idx_d < IW'(len) + IW'(11)) begin
            byte_sel = mem_q;
`ifdef FWRITE_CHECKSUM_EN
        end else if (idx_d == IW'(len) + IW'(11)) begin
            byte_sel = csum;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            rd_idx   <= '0;
            idx_d    <= '0;
            done     <= 1'b0;
            pw.pw_rdata <= 8'h00;
            file_id  <= '0;
            offset   <= '0;
            len      <= '0;
            wcnt     <= '0;
`ifdef FWRITE_CHECKSUM_EN
            csum     <= 8'h00;
`endif
        end else begin
            state  <= state_nx;
            rd_idx <= rd_idx_nx;
            idx_d  <= rd_idx;
            done   <= done_nx;
            // Two-stage prefetch: rd_idx -> (mem_q, idx_d) -> pw_rdata.
            pw.pw_rdata <= ((state == S_IDLE) || (state == S_FILL)) ? 8'h00 : byte_sel;
            if (req_fire) begin
                file_id <= req_file_id;
                offset  <= req_offset;
                len     <= req_len;
                wcnt    <= '0;
`ifdef FWRITE_CHECKSUM_EN
                csum    <= 8'h00;
`endif
            end else if (wr_fire) begin
                wcnt <= wcnt + 1'b1;
`ifdef FWRITE_CHECKSUM_EN
                csum <= csum + wr_data;
`endif
            end
        end
    end

    // Payload buffer; no reset so it maps onto block RAM.
    assign raddr = rd_idx[BUF_AW-1:0] - BUF_AW'(10);

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wcnt[BUF_AW-1:0]] <= wr_data;
        mem_q <= mem[raddr];
    end
endmodule

// File: doc/spi_dev_fwrite.md
# spi_dev_fwrite

- Write-direction counterpart of the file-read engine: the FPGA pushes a payload into an ESP32 file over the SPI slave link.
- The user side posts a request (file ID, offset, length), then streams the payload bytes into an internal buffer.
- Once the whole payload is buffered, the block raises an IRQ. The ESP32 fetches header and payload through the SPI protocol wrapper's read-arbitration interface.
- Sits beside the other command decoders on the pw_* bus; drives one pw_irq bit.

## Interface
- CMD_BYTE, 8'hF9, command byte the ESP32 sends to fetch the pending write.
- BUF_AW, 11, buffer address width. Buffer depth is 2**BUF_AW bytes; req_len is BUF_AW bits wide.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- pw_wdata  in  8  byte written by the ESP32.
- pw_wcmd  in  1  pw_wdata is the command byte of a transaction.
- pw_wstb  in  1  pw_wdata valid strobe.
- pw_end  in  1  one-cycle pulse at end of SPI transaction (CS rise).
- pw_req  out  1  request ownership of the read data path.
- pw_gnt  in  1  read path granted.
- pw_rdata  out  8  byte returned to the ESP32.
- pw_rstb  in  1  pw_rdata consumed; present the next byte.
- pw_irq  out  1  write pending, service required.
- req_file_id  in  32  target file ID.
- req_offset  in  32  byte offset in the file.
- req_len  in  BUF_AW  payload length minus one.
- req_valid / req_ready  in/out  1  request handshake.
- wr_data  in  8  payload byte.
- wr_valid / wr_ready  in/out  1  payload handshake.
- done  out  1  one-cycle pulse: payload fully delivered.

## Operation
- States: IDLE, FILL, PEND, XFER.
- IDLE: req_ready=1.
  - On req_valid&req_ready: latch file_id, offset and len; clear the write count and the checksum; go to FILL.
- FILL: wr_ready=1 while write count ≤ len.
  - Each wr_valid&wr_ready writes wr_data at the write count, then increments it.
  - The byte that brings the count to len+1 moves the state to PEND.
- PEND: pw_irq=1.
  - pw_wstb&pw_wcmd with pw_wdata==CMD_BYTE moves to XFER.
  - Other command bytes and pw_end are ignored.
- XFER: pw_irq=0, pw_req=1. The read index starts at 0.
  - Byte stream, all multi-byte fields big-endian:
    - file_id: 4 bytes.
    - offset: 4 bytes.
    - len: 2 bytes, zero-extended.
    - payload: len+1 bytes.
    - optional checksum (see Configuration).
  - Each pw_rstb advances the index. Reads past the last byte return 8'h00, and the index saturates.
- On pw_end in XFER:
  - If every stream byte was consumed: pulse done, go to IDLE.
  - Otherwise (aborted or short read): return to PEND with the read index rewound to 0. The buffer is retained and the IRQ reasserts (retry).
- Commands with any byte other than CMD_BYTE are ignored in all states.
- Buffer: a single-port-read/single-port-write EBR of 2**BUF_AW×8, registered read.
- Arithmetic: the write count is BUF_AW+1 bits wide, so a full buffer is representable. The checksum is a sum mod 256.

## Timing
- Reset values: state IDLE, req_ready=1, wr_ready=0, pw_irq=0, pw_req=0, pw_rdata=8'h00, done=0. Buffer contents are don't-care.
- req_ready and wr_ready are decoded from registered state and count only; neither depends combinationally on req_valid or wr_valid.
- pw_irq rises on the cycle after the last payload byte is accepted.
- pw_irq falls on the cycle after the CMD_BYTE strobe.
- pw_rdata is valid by the first cycle pw_gnt is high. It is updated within 2 cycles of each pw_rstb, which uses an internal prefetch to cover EBR latency. The wrapper guarantees pw_rstb spacing of ≥4 clk cycles.
- done is asserted the cycle after pw_end.
- req_len=0 gives a 1-byte payload. req_len=2**BUF_AW−1 fills the buffer exactly.
- Simultaneous pw_end and pw_rstb: the rstb counts first, then the end is evaluated.
- Reset mid-operation discards the request and buffer; outputs return to reset values asynchronously.

## Configuration
- FWRITE_CHECKSUM_EN defined: one extra byte follows the payload, the 8-bit sum mod 256 of all payload bytes.
  - The transfer counts as complete only after that byte is consumed.
  - Total stream length is len+12 bytes.
- FWRITE_CHECKSUM_EN undefined: the stream ends after the last payload byte (len+11 bytes), and no checksum logic is built.

## Test plan
- Basic write: request file 0xDABBAD00, offset 0x1000, len 3, payload 11 22 33 44.
  - pw_irq rises once the bytes are in.
  - F9 followed by 14 reads (15 with checksum) returns DA BB AD 00 00 00 10 00 00 03 11 22 33 44 [AA].
  - pw_end then produces a done pulse, and req_ready returns to 1.
- Abort/retry: end the transaction after 6 reads.
  - pw_irq reasserts and done stays 0.
  - A second full read returns the identical stream from byte 0, then done pulses.
- Wrong command: send F4 and F8 while in PEND. pw_irq stays 1, pw_req stays 0, no state change.
- Full buffer: len 0x7FF, payload i mod 256.
  - wr_ready drops after 2048 accepts.
  - Header ends 07 FF; payload byte 2047 reads 0xFF.
  - The checksum, if enabled, is 0x00.
- Backpressure: in IDLE and FILL, wr_valid held with gaps.
  - No byte is lost or duplicated.
  - req_valid asserted during FILL is not accepted (req_ready=0).
- Async reset asserted in XFER: all outputs reach reset values immediately. A fresh request completes normally afterwards.
